// File: rtl/bitfusion_pkg.sv
// Shared types and widths for the BitFusion bit-brick multiplier slice.
package bitfusion_pkg;

  localparam int BRICK_W = 2;
  localparam int PROD_W  = 6;

  typedef logic [BRICK_W-1:0]        brick_op_t;
  typedef logic signed [PROD_W-1:0]  brick_prod_t;

endpackage

// File: rtl/bit_brick_pp.sv
// Combinational core: per-operand sign extension followed by a signed 3x3 multiply.
module bit_brick_pp
  import bitfusion_pkg::*;
(
  input  brick_op_t   x,
  input  brick_op_t   y,
  input  logic        sx,
  input  logic        sy,
  output brick_prod_t p
);

  logic [2:0] xe;
  logic [2:0] ye;

  always_comb begin
    xe = sx ? {x[1], x} : {1'b0, x};
    ye = sy ? {y[1], y} : {1'b0, y};
    // Both operands are widened to the product width, so the modulo-64 product is exact.
    p  = $signed({{3{xe[2]}}, xe}) * $signed({{3{ye[2]}}, ye});
  end

endmodule

// File: rtl/bit_brick_core.sv
// 2x2-bit signed/unsigned bit brick with an optional output register.
module bit_brick_core
  import bitfusion_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic        clk,
  input  logic        nRST,
  input  brick_op_t   x,
  input  brick_op_t   y,
  input  logic        sx,
  input  logic        sy,
  output brick_prod_t product
);

  brick_prod_t p_d;

  bit_brick_pp u_pp (
    .x  (x),
    .y  (y),
    .sx (sx),
    .sy (sy),
    .p  (p_d)
  );

  generate
    if (OUT_REG) begin : g_reg
      brick_prod_t product_q;

      // nRST is active-high despite its name.
      always_ff @(posedge clk or posedge nRST) begin
        if (nRST) product_q <= '0;
        else      product_q <= p_d;
      end

      assign product = product_q;
    end else begin : g_bypass
      assign product = p_d;
    end
  endgenerate

endmodule

// File: tb/tb_bit_brick_core.sv
// Self-checking bench for bit_brick_core: directed table, exhaustive, random and reset cases.
module tb_bit_brick_core;

  logic       clk;
  logic       nRST;
  logic [1:0] x;
  logic [1:0] y;
  logic       sx;
  logic       sy;
  logic signed [5:0] product;

  int n_tests;
  int n_fail;

  bit_brick_core dut (
    .clk     (clk),
    .nRST    (nRST),
    .x       (x),
    .y       (y),
    .sx      (sx),
    .sy      (sy),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    logic       sx;
    logic       sy;
    int         exp;
  } vec_t;

  vec_t vecs[10];

  function automatic int ref_prod(input logic [1:0] a, input logic [1:0] b,
                                  input logic sa, input logic sb);
    int av;
    int bv;
    av = int'(a);
    bv = int'(b);
    if (sa && a[1]) av = av - 4;
    if (sb && b[1]) bv = bv - 4;
    return av * bv;
  endfunction

  task automatic check(input string name, input int exp);
    n_tests++;
    if (int'(product) != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, int'(product), exp);
    end
  endtask

  task automatic apply(input logic [1:0] a, input logic [1:0] b,
                       input logic sa, input logic sb, input string name, input int exp);
    @(negedge clk);
    x = a; y = b; sx = sa; sy = sb;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{2'd0, 2'd0, 1'b0, 1'b0,  0};
    vecs[1] = '{2'd1, 2'd0, 1'b0, 1'b0,  0};
    vecs[2] = '{2'd0, 2'd1, 1'b0, 1'b0,  0};
    vecs[3] = '{2'd1, 2'd1, 1'b0, 1'b0,  1};
    vecs[4] = '{2'd3, 2'd3, 1'b0, 1'b0,  9};
    vecs[5] = '{2'b10, 2'b11, 1'b1, 1'b0, -6};
    vecs[6] = '{2'b11, 2'b10, 1'b0, 1'b1, -6};
    vecs[7] = '{2'b11, 2'b11, 1'b1, 1'b1,  1};
    vecs[8] = '{2'b10, 2'b10, 1'b1, 1'b1,  4};
    vecs[9] = '{2'b10, 2'b01, 1'b1, 1'b1, -2};

    // Reset held with live operands: output must be zero before any clock edge.
    nRST = 1'b1;
    x = 2'd3; y = 2'd3; sx = 1'b0; sy = 1'b0;
    #2;
    check("reset_async", 0);
    @(negedge clk);
    nRST = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 9);

    foreach (vecs[i])
      apply(vecs[i].x, vecs[i].y, vecs[i].sx, vecs[i].sy, $sformatf("vec%0d", i), vecs[i].exp);

    for (int k = 0; k < 64; k++) begin
      logic [5:0] c;
      c = 6'(k);
      apply(c[5:4], c[3:2], c[1], c[0], $sformatf("exh%0d", k),
            ref_prod(c[5:4], c[3:2], c[1], c[0]));
    end

    for (int k = 0; k < 200; k++) begin
      logic [5:0] r;
      r = 6'($urandom_range(0, 63));
      apply(r[5:4], r[3:2], r[1], r[0], $sformatf("rnd%0d", k),
            ref_prod(r[5:4], r[3:2], r[1], r[0]));
    end

    // Mid-stream reset: result drops within the cycle and stays zero across an edge.
    apply(2'd3, 2'd3, 1'b0, 1'b0, "pre_reset", 9);
    @(negedge clk);
    x = 2'b10; y = 2'b10; sx = 1'b1; sy = 1'b1;
    nRST = 1'b1;
    #1;
    check("mid_reset_async", 0);
    @(posedge clk);
    #1;
    check("mid_reset_hold", 0);
    @(negedge clk);
    nRST = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_release", 4);

    // Back-to-back changes confirm exactly one cycle of latency.
    @(negedge clk);
    x = 2'b10; y = 2'b11; sx = 1'b1; sy = 1'b0;
    #1;
    check("latency_hold", 4);
    @(posedge clk);
    #1;
    check("latency_load", -6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
